// File: rtl/cnn_layer_accel_wht_table_pingpong_if.sv
// Bus bundle for the ping-pong kernel weight table: config/DMA fill side,
// bank status, and the CE read side. The master drives requests; the table
// (slave) returns status and weights.
interface cnn_layer_accel_wht_table_pingpong_if #(
  parameter int C_WEIGHT_WIDTH   = 16,
  parameter int C_NUM_RD_PORTS   = 2,
  parameter int C_MAX_KERNELS    = 64,
  parameter int C_SEQ_ADDR_WIDTH = 4
);
  localparam int CNT_W = $clog2(C_MAX_KERNELS + 1);
  localparam int KG_W  = (C_MAX_KERNELS > 1) ? $clog2(C_MAX_KERNELS) : 1;
  localparam int TAP_W = C_SEQ_ADDR_WIDTH + 1;

  // Job control and shadow descriptor
  logic                                       job_accept;
  logic                                       cfg_valid;
  logic [CNT_W-1:0]                           cfg_num_kernels;
  logic [TAP_W-1:0]                           cfg_taps;

  // Weight fill path
  logic                                       wht_cfg_wren;
  logic [C_WEIGHT_WIDTH-1:0]                  wht_cfg_data;

  // Bank status
  logic                                       shadow_loaded;
  logic                                       wr_overflow;
  logic                                       active_valid;

  // CE read path
  logic                                       ce_execute;
  logic                                       next_kernel;
  logic [C_NUM_RD_PORTS*C_SEQ_ADDR_WIDTH-1:0] wht_seq_addr;
  logic [C_NUM_RD_PORTS*C_WEIGHT_WIDTH-1:0]   wht_table_dout;
  logic                                       wht_table_dout_valid;
  logic [KG_W-1:0]                            kernel_group;
  logic                                       last_kernel;

  modport master (
    output job_accept, cfg_valid, cfg_num_kernels, cfg_taps,
           wht_cfg_wren, wht_cfg_data,
           ce_execute, next_kernel, wht_seq_addr,
    input  shadow_loaded, wr_overflow, active_valid,
           wht_table_dout, wht_table_dout_valid, kernel_group, last_kernel
  );

  modport slave (
    input  job_accept, cfg_valid, cfg_num_kernels, cfg_taps,
           wht_cfg_wren, wht_cfg_data,
           ce_execute, next_kernel, wht_seq_addr,
    output shadow_loaded, wr_overflow, active_valid,
           wht_table_dout, wht_table_dout_valid, kernel_group, last_kernel
  );
endinterface

// File: rtl/cnn_layer_accel_wht_table_pingpong.sv
// Double-buffered kernel weight table for one convolution engine.
// The config path fills the shadow bank while the CE reads the active bank;
// a job_accept with a complete shadow bank swaps the two. Each read port has
// its own RAM copy so all DSP lanes read in the same cycle.
module cnn_layer_accel_wht_table_pingpong #(
  parameter int C_WEIGHT_WIDTH   = 16,
  parameter int C_NUM_RD_PORTS   = 2,
  parameter int C_MAX_KERNELS    = 64,
  parameter int C_SEQ_ADDR_WIDTH = 4,
  parameter int C_SEQ_ADDR_DELAY = 3,
  parameter int C_RAM_RD_LATENCY = 3
) (
  input  logic                                 clk,
  input  logic                                 rst,
  cnn_layer_accel_wht_table_pingpong_if.slave  bus
);

  localparam int CNT_W     = $clog2(C_MAX_KERNELS + 1);
  localparam int KG_W      = (C_MAX_KERNELS > 1) ? $clog2(C_MAX_KERNELS) : 1;
  localparam int SAW       = C_SEQ_ADDR_WIDTH;
  localparam int TAP_W     = SAW + 1;
  localparam int ADDR_W    = 1 + KG_W + SAW;
  localparam int DEPTH     = 2 * C_MAX_KERNELS * (2 ** SAW);
  localparam int SEQ_BUS_W = C_NUM_RD_PORTS * SAW;
  // next_kernel lands on kernel_group in the same cycle its data leaves the RAM
  localparam int NK_DLY    = C_SEQ_ADDR_DELAY + C_RAM_RD_LATENCY - 1;

  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(C_MAX_KERNELS);
  localparam logic [TAP_W-1:0] MAX_TAPS = TAP_W'(2 ** SAW);

  typedef enum logic {
    SH_FILL   = 1'b0,
    SH_LOADED = 1'b1
  } sh_state_t;

  // Index of the last entry for a descriptor value; a zero descriptor acts as one.
  function automatic logic [CNT_W-1:0] cnt_last(input logic [CNT_W-1:0] c);
    return (c == '0) ? '0 : c - CNT_W'(1);
  endfunction

  // ---------------------------------------------------------------------------
  // Shadow bank state
  // ---------------------------------------------------------------------------
  sh_state_t        sh_state, sh_next;
  logic [CNT_W-1:0] shadow_count;
  logic [TAP_W-1:0] shadow_taps;
  logic [KG_W-1:0]  wr_kern;
  logic [SAW-1:0]   wr_tap;
  logic             do_write, do_swap, ovf_next;
  logic             tap_wrap, wr_final;
  logic [CNT_W-1:0] sh_cnt_last;
  logic [TAP_W-1:0] sh_taps_last;
  logic             wr_overflow_q;

  // ---------------------------------------------------------------------------
  // Active bank state
  // ---------------------------------------------------------------------------
  logic             bank_sel;
  logic [CNT_W-1:0] active_count, cnt_next;
  logic             active_valid_q, av_next;
  logic [KG_W-1:0]  kernel_group_q, kg_next;
  logic             last_kernel_q, last_next;
  logic [NK_DLY-1:0] nk_pipe;
  logic             nk_fire;

  // ---------------------------------------------------------------------------
  // Read pipeline
  // ---------------------------------------------------------------------------
  logic                        rd_en;
  logic [C_SEQ_ADDR_DELAY-1:0] seq_vld;
  logic [SEQ_BUS_W-1:0]        seq_pipe [C_SEQ_ADDR_DELAY];
  logic [SEQ_BUS_W-1:0]        seq_tail;
  logic [C_RAM_RD_LATENCY-1:0] ram_vld;
  logic [C_WEIGHT_WIDTH-1:0]   ram_tail [C_NUM_RD_PORTS];
  logic [SEQ_BUS_W/SAW*C_WEIGHT_WIDTH-1:0] dout_q;
  logic [ADDR_W-1:0]           wr_addr;

  assign sh_cnt_last  = cnt_last(shadow_count);
  assign sh_taps_last = (shadow_taps == '0) ? '0 : shadow_taps - TAP_W'(1);
  assign tap_wrap     = ({1'b0, wr_tap} == sh_taps_last);
  assign wr_final     = tap_wrap && (CNT_W'(wr_kern) == sh_cnt_last);
  assign wr_addr      = {~bank_sel, wr_kern, wr_tap};

  // Shadow fill state register.
  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values regardless of the order of always blocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sh_state <= SH_FILL;
    else     sh_state <= sh_next;
  end

  // Shadow fill next state: accept writes while filling, swap once loaded.
  // NOTE: every output of this block gets a default first, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    sh_next  = sh_state;
    do_write = 1'b0;
    do_swap  = 1'b0;
    ovf_next = 1'b0;
    unique case (sh_state)
      SH_FILL: begin
        if (bus.wht_cfg_wren) begin
          do_write = 1'b1;
          if (wr_final) sh_next = SH_LOADED;
        end
      end
      SH_LOADED: begin
        if (bus.wht_cfg_wren) ovf_next = 1'b1;
        if (bus.job_accept) begin
          do_swap = 1'b1;
          sh_next = SH_FILL;
        end
      end
      default: sh_next = SH_FILL;
    endcase
  end

  // Shadow descriptor capture, write counters and overflow pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_count  <= '0;
      shadow_taps   <= '0;
      wr_kern       <= '0;
      wr_tap        <= '0;
      wr_overflow_q <= 1'b0;
    end else begin
      wr_overflow_q <= ovf_next;
      // A loaded shadow is frozen until it is swapped in.
      if (bus.cfg_valid && (sh_state == SH_FILL)) begin
        if (bus.cfg_num_kernels == '0)          shadow_count <= CNT_W'(1);
        else if (bus.cfg_num_kernels > MAX_CNT) shadow_count <= MAX_CNT;
        else                                    shadow_count <= bus.cfg_num_kernels;
        if (bus.cfg_taps == '0)                 shadow_taps  <= TAP_W'(1);
        else if (bus.cfg_taps > MAX_TAPS)       shadow_taps  <= MAX_TAPS;
        else                                    shadow_taps  <= bus.cfg_taps;
      end
      if (do_write) begin
        if (wr_final) begin
          wr_kern <= '0;
          wr_tap  <= '0;
        end else if (tap_wrap) begin
          wr_kern <= wr_kern + KG_W'(1);
          wr_tap  <= '0;
        end else begin
          wr_tap  <= wr_tap + SAW'(1);
        end
      end
    end
  end

  // Delay next_kernel so the kernel switch lines up with the read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nk_pipe <= '0;
    end else begin
      nk_pipe[0] <= bus.next_kernel;
      for (int i = 1; i < NK_DLY; i++) nk_pipe[i] <= nk_pipe[i-1];
    end
  end

  assign nk_fire = nk_pipe[NK_DLY-1];

  // Active descriptor next values: swap, kernel stepping, and the last-kernel
  // flag computed from the next kernel_group so it carries no extra latency.
  always_comb begin
    kg_next  = kernel_group_q;
    av_next  = active_valid_q;
    cnt_next = active_count;
    if (do_swap) begin
      av_next  = 1'b1;
      cnt_next = shadow_count;
    end
    if (bus.job_accept) begin
      kg_next = '0;
    end else if (nk_fire) begin
      kg_next = (CNT_W'(kernel_group_q) >= cnt_last(active_count))
                ? '0 : kernel_group_q + KG_W'(1);
    end
    last_next = av_next && (CNT_W'(kg_next) == cnt_last(cnt_next));
  end

  // Active bank registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_sel       <= 1'b0;
      active_count   <= '0;
      active_valid_q <= 1'b0;
      kernel_group_q <= '0;
      last_kernel_q  <= 1'b0;
    end else begin
      if (do_swap) bank_sel <= ~bank_sel;
      active_count   <= cnt_next;
      active_valid_q <= av_next;
      kernel_group_q <= kg_next;
      last_kernel_q  <= last_next;
    end
  end

  assign rd_en = bus.ce_execute && active_valid_q;

  // Read-enable and RAM valid shift registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq_vld <= '0;
      ram_vld <= '0;
    end else begin
      seq_vld[0] <= rd_en;
      for (int i = 1; i < C_SEQ_ADDR_DELAY; i++) seq_vld[i] <= seq_vld[i-1];
      ram_vld[0] <= seq_vld[C_SEQ_ADDR_DELAY-1];
      for (int i = 1; i < C_RAM_RD_LATENCY; i++) ram_vld[i] <= ram_vld[i-1];
    end
  end

  // Tap-address delay line; pure data path, qualified by seq_vld.
  always_ff @(posedge clk) begin
    seq_pipe[0] <= bus.wht_seq_addr;
    for (int i = 1; i < C_SEQ_ADDR_DELAY; i++) seq_pipe[i] <= seq_pipe[i-1];
  end

  assign seq_tail = seq_pipe[C_SEQ_ADDR_DELAY-1];

  // One RAM copy per read port, all written together from the fill path.
  for (genvar p = 0; p < C_NUM_RD_PORTS; p++) begin : g_port
    logic [C_WEIGHT_WIDTH-1:0] mem    [DEPTH];
    logic [C_WEIGHT_WIDTH-1:0] q_pipe [C_RAM_RD_LATENCY-1];
    logic [ADDR_W-1:0]         rd_addr;

    assign rd_addr = {bank_sel, kernel_group_q, seq_tail[p*SAW +: SAW]};

    // Write into the shadow half, read the active half, then the BRAM output stages.
    // NOTE: the RAM and its output stages are not reset; contents are only
    // meaningful once written, and validity is carried by the reset flags.
    always_ff @(posedge clk) begin
      if (do_write) mem[wr_addr] <= bus.wht_cfg_data;
      if (seq_vld[C_SEQ_ADDR_DELAY-1]) q_pipe[0] <= mem[rd_addr];
      for (int i = 1; i < C_RAM_RD_LATENCY-1; i++) q_pipe[i] <= q_pipe[i-1];
    end

    assign ram_tail[p] = q_pipe[C_RAM_RD_LATENCY-2];
  end

  // Output register: loads on valid data, otherwise holds the last weights.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q <= '0;
    end else if (ram_vld[C_RAM_RD_LATENCY-2]) begin
      for (int p = 0; p < C_NUM_RD_PORTS; p++)
        dout_q[p*C_WEIGHT_WIDTH +: C_WEIGHT_WIDTH] <= ram_tail[p];
    end
  end

  assign bus.shadow_loaded        = (sh_state == SH_LOADED);
  assign bus.wr_overflow          = wr_overflow_q;
  assign bus.active_valid         = active_valid_q;
  assign bus.wht_table_dout       = dout_q;
  assign bus.wht_table_dout_valid = ram_vld[C_RAM_RD_LATENCY-1];
  assign bus.kernel_group         = kernel_group_q;
  assign bus.last_kernel          = last_kernel_q;

endmodule
